// File: rtl/ysyx_22040127_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, requester ids, default widths.
package ysyx_22040127_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22040127_arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// ARB_RR_EN defined: on a collision the requester not granted last wins.
// ARB_RR_EN undefined: LSU always beats IFU; last_grant is ignored.
module ysyx_22040127_arb_pick
  import ysyx_22040127_mem_arbiter_pkg::*;
(
  input  logic   if_valid,
  input  logic   ls_valid,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant
);

  // Pick a winner whenever at least one requester is valid.
  always_comb begin
    grant_valid = if_valid | ls_valid;
    grant       = OwnIfu;
`ifdef ARB_RR_EN
    if (if_valid && ls_valid) begin
      grant = (last_grant == OwnLsu) ? OwnIfu : OwnLsu;
    end else if (ls_valid) begin
      grant = OwnLsu;
    end
`else
    if (ls_valid) begin
      grant = OwnLsu;
    end
`endif
  end

`ifndef ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU (read/write).
// One outstanding transaction; the response is routed only to the granted owner.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of fixed LSU priority.
module ysyx_22040127_mem_arbiter
  import ysyx_22040127_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  input  logic                if_resp_ready,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  input  logic                ls_resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                mem_resp_ready
);

  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  owner_e              last_grant;
  logic                grant_valid;
  owner_e              grant;
  logic                owner_resp_ready;

`ifdef ARB_RR_EN
  owner_e last_grant_q;
  assign last_grant = last_grant_q;

  // Remember who completed most recently so the other side wins the next collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= OwnLsu;
    end else if (state_q == StWait && mem_resp_valid && owner_resp_ready) begin
      last_grant_q <= owner_q;
    end
  end
`else
  assign last_grant = OwnLsu;
`endif

  ysyx_22040127_arb_pick u_pick (
    .if_valid    (if_req_valid),
    .ls_valid    (ls_req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign owner_resp_ready = (owner_q == OwnLsu) ? ls_resp_ready : if_resp_ready;
  assign resp_rdata       = mem_resp_rdata;
  assign mem_req_addr     = addr_q;
  assign mem_req_wdata    = wdata_q;
  assign mem_req_wmask    = wmask_q;

  // Next-state, payload capture and handshake outputs.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    if_req_ready   = 1'b0;
    ls_req_ready   = 1'b0;
    mem_req_valid  = 1'b0;
    if_resp_valid  = 1'b0;
    ls_resp_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StIssue;
          owner_d = grant;
          if (grant == OwnLsu) begin
            ls_req_ready = 1'b1;
            addr_d       = ls_req_addr;
            wdata_d      = ls_req_wdata;
            wmask_d      = ls_req_wmask;
          end else begin
            if_req_ready = 1'b1;
            addr_d       = if_req_addr;
            wdata_d      = '0;
            wmask_d      = '0;
          end
        end
      end
      StIssue: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        mem_resp_ready = owner_resp_ready;
        if_resp_valid  = (owner_q == OwnIfu) && mem_resp_valid;
        ls_resp_valid  = (owner_q == OwnLsu) && mem_resp_valid;
        if (mem_resp_valid && owner_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Handshake outputs are forced low for as long as reset is held.
    if (!rst) begin
      if_req_ready   = 1'b0;
      ls_req_ready   = 1'b0;
      mem_req_valid  = 1'b0;
      if_resp_valid  = 1'b0;
      ls_resp_valid  = 1'b0;
      mem_resp_ready = 1'b0;
    end
  end

  // State, owner and registered request payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= OwnIfu;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_ysyx_22040127_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_req_addr = '0;
  logic        if_resp_valid, if_resp_ready = 1'b0;
  logic        ls_req_valid = 1'b0, ls_req_ready;
  logic [31:0] ls_req_addr = '0;
  logic [63:0] ls_req_wdata = '0;
  logic [7:0]  ls_req_wmask = '0;
  logic        ls_resp_valid, ls_resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0, mem_resp_ready;
  logic [63:0] mem_resp_rdata = '0;

  always #5 clk = ~clk;

  ysyx_22040127_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
    .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_ready(mem_resp_ready)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;
  int if_deliv = 0;
  int ls_deliv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_fn(input logic [31:0] a);
    return {a ^ 32'h5a5a_5a5a, ~a};
  endfunction

  // Reference model: one transaction in flight, described by busy/issued flags and its payload.
  logic        m_busy, m_issued, m_owner_ls, m_last_ls;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wmask;
  logic        m_win_ls, m_ordy;
  logic        e_if_rdy, e_ls_rdy, e_mreq_v, e_if_rv, e_ls_rv, e_mresp_rdy;
  logic        prev_if_wait, prev_ls_wait;
  logic [31:0] prev_if_addr, prev_ls_addr;
  logic [63:0] prev_ls_wdata;
  logic [7:0]  prev_ls_wmask;

  always_comb begin
    m_win_ls = ls_req_valid;
    if (if_req_valid && ls_req_valid) begin
`ifdef ARB_RR_EN
      m_win_ls = !m_last_ls;
`else
      m_win_ls = 1'b1;
`endif
    end
    m_ordy      = m_owner_ls ? ls_resp_ready : if_resp_ready;
    e_if_rdy    = rst && !m_busy && if_req_valid && !m_win_ls;
    e_ls_rdy    = rst && !m_busy && ls_req_valid && m_win_ls;
    e_mreq_v    = rst && m_busy && !m_issued;
    e_if_rv     = rst && m_issued && !m_owner_ls && mem_resp_valid;
    e_ls_rv     = rst && m_issued && m_owner_ls && mem_resp_valid;
    e_mresp_rdy = rst && m_issued && m_ordy;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_issued = 0; m_owner_ls = 0; m_last_ls = 1;
      m_addr = '0; m_wdata = '0; m_wmask = '0;
      prev_if_wait = 0; prev_ls_wait = 0;
      prev_if_addr = '0; prev_ls_addr = '0; prev_ls_wdata = '0; prev_ls_wmask = '0;
    end else begin
      // Requesters must hold valid and payload until accepted.
      if (prev_if_wait) check("if_hold", {if_req_valid, if_req_addr}, {1'b1, prev_if_addr});
      if (prev_ls_wait) begin
        check("ls_hold", {ls_req_valid, ls_req_wmask, ls_req_addr},
              {1'b1, prev_ls_wmask, prev_ls_addr});
        check("ls_hold_wdata", ls_req_wdata, prev_ls_wdata);
      end
      prev_if_wait = if_req_valid && !e_if_rdy;
      prev_ls_wait = ls_req_valid && !e_ls_rdy;
      prev_if_addr = if_req_addr;
      prev_ls_addr = ls_req_addr;
      prev_ls_wdata = ls_req_wdata;
      prev_ls_wmask = ls_req_wmask;
      if (e_if_rdy || e_ls_rdy) begin
        m_busy = 1;
        m_owner_ls = e_ls_rdy;
        m_addr = e_ls_rdy ? ls_req_addr : if_req_addr;
        m_wdata = e_ls_rdy ? ls_req_wdata : m_wdata;
        m_wmask = e_ls_rdy ? ls_req_wmask : 8'h00;
      end else if (e_mreq_v && mem_req_ready) begin
        m_issued = 1;
      end else if (e_mresp_rdy && mem_resp_valid) begin
        m_busy = 0;
        m_issued = 0;
        m_last_ls = m_owner_ls;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("if_req_ready", if_req_ready, e_if_rdy);
      check("ls_req_ready", ls_req_ready, e_ls_rdy);
      check("mem_req_valid", mem_req_valid, e_mreq_v);
      check("if_resp_valid", if_resp_valid, e_if_rv);
      check("ls_resp_valid", ls_resp_valid, e_ls_rv);
      check("mem_resp_ready", mem_resp_ready, e_mresp_rdy);
      if (e_mreq_v) begin
        check("mem_req_addr", mem_req_addr, m_addr);
        check("mem_req_wmask", mem_req_wmask, m_wmask);
        if (m_owner_ls) check("mem_req_wdata", mem_req_wdata, m_wdata);
      end
      if (rand_mode && (e_if_rv || e_ls_rv)) check("resp_rdata", resp_rdata, mem_fn(m_addr));
      if (if_resp_valid && if_resp_ready) if_deliv++;
      if (ls_resp_valid && ls_resp_ready) ls_deliv++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit          if_hs, ls_hs, mreq_hs, mresp_hs;
  bit          pend;
  int          delay;
  int          d0;
  logic [31:0] paddr, req_addr_s;

  initial begin
    // Reset values, with an LSU request present to show ready stays low.
    ls_req_valid = 1'b1;
    #2;
    check("rst_ls_req_ready", ls_req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_mem_req_wdata", mem_req_wdata, 0);
    check("rst_mem_req_wmask", mem_req_wmask, 0);
    repeat (2) @(posedge clk);
    #1;
    ls_req_valid = 1'b0;
    rst = 1'b1;
    chk_en = 1'b1;

    // IFU read with single-cycle memory.
    if_req_valid = 1; if_req_addr = 32'h8000_0000; if_resp_ready = 1; mem_req_ready = 1;
    @(negedge clk);
    check("t1_if_req_ready", if_req_ready, 1);
    check("t1_mem_req_valid_T", mem_req_valid, 0);
    tick(); if_req_valid = 0;
    @(negedge clk);
    check("t1_mem_req_valid", mem_req_valid, 1);
    check("t1_mem_req_addr", mem_req_addr, 64'h8000_0000);
    check("t1_mem_req_wmask", mem_req_wmask, 0);
    check("t1_if_req_ready_T1", if_req_ready, 0);
    tick(); mem_resp_valid = 1; mem_resp_rdata = 64'h0010_0073;
    @(negedge clk);
    check("t1_if_resp_valid", if_resp_valid, 1);
    check("t1_resp_rdata", resp_rdata, 64'h0010_0073);
    check("t1_ls_resp_valid", ls_resp_valid, 0);
    tick(); mem_resp_valid = 0;
    @(negedge clk);
    check("t1_if_resp_valid_done", if_resp_valid, 0);

    // Collision: LSU write wins, IFU follows after the LSU handshake.
    tick();
    if_req_valid = 1; if_req_addr = 32'h8000_0004;
    ls_req_valid = 1; ls_req_addr = 32'h8000_1000; ls_req_wdata = 64'hDEAD_BEEF;
    ls_req_wmask = 8'h0F; ls_resp_ready = 1;
    @(negedge clk);
    check("t2_ls_req_ready", ls_req_ready, 1);
    check("t2_if_req_ready", if_req_ready, 0);
    tick(); ls_req_valid = 0;
    @(negedge clk);
    check("t2_mem_req_addr", mem_req_addr, 64'h8000_1000);
    check("t2_mem_req_wdata", mem_req_wdata, 64'hDEAD_BEEF);
    check("t2_mem_req_wmask", mem_req_wmask, 8'h0F);
    tick(); mem_resp_valid = 1; mem_resp_rdata = '0;
    @(negedge clk);
    check("t2_ls_resp_valid", ls_resp_valid, 1);
    check("t2_if_resp_valid", if_resp_valid, 0);
    check("t2_if_req_ready_wait", if_req_ready, 0);
    tick(); mem_resp_valid = 0;
    @(negedge clk);
    check("t2_if_req_ready_idle", if_req_ready, 1);
    tick(); if_req_valid = 0;
    @(negedge clk);
    check("t2_if_mem_req_addr", mem_req_addr, 64'h8000_0004);
    check("t2_if_mem_req_wmask", mem_req_wmask, 0);
    tick(); mem_resp_valid = 1; mem_resp_rdata = 64'h1;
    @(negedge clk);
    check("t2_if_resp_valid", if_resp_valid, 1);
    tick(); mem_resp_valid = 0;

    // Memory stalls acceptance for 5 cycles; IFU waits behind.
    mem_req_ready = 0;
    ls_req_valid = 1; ls_req_addr = 32'h8000_2000; ls_req_wdata = 64'h1234; ls_req_wmask = 0;
    if_req_valid = 1; if_req_addr = 32'h8000_0008;
    @(negedge clk);
    check("t3_ls_req_ready", ls_req_ready, 1);
    tick(); ls_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_mem_req_valid", mem_req_valid, 1);
      check("t3_mem_req_addr", mem_req_addr, 64'h8000_2000);
      check("t3_mem_req_wdata", mem_req_wdata, 64'h1234);
      check("t3_req_readys", {if_req_ready, ls_req_ready}, 0);
      tick();
    end
    mem_req_ready = 1;
    tick();

    // Response backpressure in WAIT: one delivery only.
    mem_resp_valid = 1; mem_resp_rdata = 64'hCAFE; ls_resp_ready = 0; d0 = ls_deliv;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_mem_resp_ready", mem_resp_ready, 0);
      check("t4_ls_resp_valid", ls_resp_valid, 1);
      check("t4_if_req_ready", if_req_ready, 0);
      tick();
    end
    ls_resp_ready = 1;
    @(negedge clk);
    check("t4_mem_resp_ready_hs", mem_resp_ready, 1);
    check("t4_resp_rdata", resp_rdata, 64'hCAFE);
    tick();
    // mem_resp_valid left high in IDLE and ISSUE must be ignored.
    @(negedge clk);
    check("t4_ls_resp_valid_idle", ls_resp_valid, 0);
    check("t4_mem_resp_ready_idle", mem_resp_ready, 0);
    check("t4_if_req_ready_idle", if_req_ready, 1);
    check("t4_one_delivery", ls_deliv - d0, 1);
    tick(); if_req_valid = 0;
    @(negedge clk);
    check("t4_if_resp_valid_issue", if_resp_valid, 0);
    check("t4_mem_resp_ready_issue", mem_resp_ready, 0);
    tick();

    // Reset asserted in WAIT drops every handshake output at once.
    ls_req_valid = 1; ls_req_addr = 32'h8000_3000;
    #1;
    check("t5_if_resp_valid_pre", if_resp_valid, 1);
    rst = 0;
    #1;
    check("t5_handshakes", {if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid,
                            ls_resp_valid, mem_resp_ready}, 0);
    check("t5_mem_req_addr", mem_req_addr, 0);
    tick(); tick();
    rst = 1; ls_req_valid = 0; mem_resp_valid = 0;
    if_req_valid = 1; if_req_addr = 32'h8000_0010;
    @(negedge clk);
    check("t5_if_req_ready", if_req_ready, 1);
    tick(); if_req_valid = 0;
    @(negedge clk);
    check("t5_mem_req_addr_new", mem_req_addr, 64'h8000_0010);
    tick(); mem_resp_valid = 1; mem_resp_rdata = 64'h13;
    @(negedge clk);
    check("t5_if_resp_valid", if_resp_valid, 1);
    check("t5_resp_rdata", resp_rdata, 64'h13);
    tick(); mem_resp_valid = 0;

    // Randomized traffic with a memory stub of variable latency.
    rand_mode = 1; pend = 0; delay = 0; paddr = '0; d0 = if_deliv + ls_deliv;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if_hs = if_req_valid && if_req_ready;
      ls_hs = ls_req_valid && ls_req_ready;
      mreq_hs = mem_req_valid && mem_req_ready;
      mresp_hs = mem_resp_valid && mem_resp_ready;
      req_addr_s = mem_req_addr;
      tick();
      if (if_hs) if_req_valid = 0;
      if (!if_req_valid && $urandom_range(2) == 0) begin
        if_req_valid = 1;
        if_req_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (ls_hs) ls_req_valid = 0;
      if (!ls_req_valid && $urandom_range(2) == 0) begin
        ls_req_valid = 1;
        ls_req_addr = $urandom;
        ls_req_wdata = {$urandom, $urandom};
        ls_req_wmask = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
      end
      if_resp_ready = ($urandom_range(3) != 0);
      ls_resp_ready = ($urandom_range(3) != 0);
      mem_req_ready = ($urandom_range(1) == 1);
      if (mresp_hs) pend = 0;
      if (mreq_hs) begin
        pend = 1;
        delay = $urandom_range(2);
        paddr = req_addr_s;
      end
      if (pend) begin
        if (delay > 0) begin
          delay--;
          mem_resp_valid = 0;
        end else begin
          mem_resp_valid = 1;
          mem_resp_rdata = mem_fn(paddr);
        end
      end else begin
        mem_resp_valid = ($urandom_range(4) == 0);
        mem_resp_rdata = {$urandom, $urandom};
      end
    end
    check("rand_progress", (if_deliv + ls_deliv - d0) > 200, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
